tulip_dsp_prog_sequencer: RTL and testbench

Host-side programming sequencer for the tulip DSP chain. It owns the three coefficient-programming ports: LUT transfer function, user FIR taps and reverb taps. One command does three things in order: soft-resets the selected stage, streams a fixed number of host words into it, then waits for that stage's done flag. It sits between the register/DMA front end and the DSP top, and drives that top's `*_sw_resetn` and `*_prog_din*` inputs.

---
 rtl/tulip_dsp_prog_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_tulip_dsp_prog_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tulip_dsp_prog_sequencer.sv
// Host-side programming sequencer for the tulip DSP chain.
// One command soft-resets the selected stage (LUT, user FIR or reverb),
// streams word_count host words into its programming port, then waits for
// the stage's done flag (bounded by G_TIMEOUT).
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, target, word_count  command strobe, stage select (3=invalid), length
//   busy, done_pulse, error    status: not idle, end-of-command strobe, sticky error
//   host_din/_valid/_ready     host word stream
//   *_sw_resetn                active-low stage soft resets
//   lut_/fir_/rev_prog_*       per-stage programming ports (din/valid out, ready/done in)
module tulip_dsp_prog_sequencer #(
  parameter int unsigned G_DWIDTH       = 24,
  parameter int unsigned G_TAP_DWIDTH   = 16,
  parameter int unsigned G_RESET_CYCLES = 4,
  parameter int unsigned G_TIMEOUT      = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [1:0]              target,
  input  logic [15:0]             word_count,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    error,
  input  logic [G_DWIDTH-1:0]     host_din,
  input  logic                    host_din_valid,
  output logic                    host_din_ready,
  output logic                    lut_sw_resetn,
  output logic                    usr_fir_sw_resetn,
  output logic                    reverb_sw_resetn,
  output logic [G_DWIDTH-1:0]     lut_prog_din,
  output logic                    lut_prog_valid,
  input  logic                    lut_prog_ready,
  input  logic                    lut_prog_done,
  output logic [G_TAP_DWIDTH-1:0] fir_prog_din,
  output logic                    fir_prog_valid,
  input  logic                    fir_prog_ready,
  input  logic                    fir_prog_done,
  output logic [G_TAP_DWIDTH-1:0] rev_prog_din,
  output logic                    rev_prog_valid,
  input  logic                    rev_prog_ready,
  input  logic                    rev_prog_done
);

  localparam int unsigned WC_W  = 16;
  localparam int unsigned RST_W = $clog2(G_RESET_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(G_TIMEOUT + 1);

  localparam logic [1:0] TGT_LUT = 2'd0;
  localparam logic [1:0] TGT_FIR = 2'd1;
  localparam logic [1:0] TGT_REV = 2'd2;
  localparam logic [1:0] TGT_BAD = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_LOAD,
    S_WAIT_DONE,
    S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [WC_W-1:0]   count_q, count_d;
  logic [WC_W-1:0]   xfer_q, xfer_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [TO_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              error_q, error_d;

  logic              sel_ready;
  logic              sel_done;
  logic              in_load;
  logic              xfer;
  logic [WC_W-1:0]   xfer_inc;

  // Route the selected stage's handshake inputs.
  always_comb begin
    sel_ready = 1'b0;
    sel_done  = 1'b0;
    case (tgt_q)
      TGT_LUT: begin sel_ready = lut_prog_ready; sel_done = lut_prog_done; end
      TGT_FIR: begin sel_ready = fir_prog_ready; sel_done = fir_prog_done; end
      TGT_REV: begin sel_ready = rev_prog_ready; sel_done = rev_prog_done; end
      default: ;
    endcase
  end

  // Zero-latency data path, only open in LOAD.
  assign in_load        = (state_q == S_LOAD);
  assign host_din_ready = in_load & sel_ready;
  assign xfer           = host_din_valid & host_din_ready;
  assign xfer_inc       = xfer_q + WC_W'(1);

  assign lut_prog_din   = host_din;
  assign fir_prog_din   = host_din[G_TAP_DWIDTH-1:0];
  assign rev_prog_din   = host_din[G_TAP_DWIDTH-1:0];
  assign lut_prog_valid = in_load && (tgt_q == TGT_LUT) && host_din_valid;
  assign fir_prog_valid = in_load && (tgt_q == TGT_FIR) && host_din_valid;
  assign rev_prog_valid = in_load && (tgt_q == TGT_REV) && host_din_valid;

  assign lut_sw_resetn     = !((state_q == S_RST) && (tgt_q == TGT_LUT));
  assign usr_fir_sw_resetn = !((state_q == S_RST) && (tgt_q == TGT_FIR));
  assign reverb_sw_resetn  = !((state_q == S_RST) && (tgt_q == TGT_REV));

  assign busy       = (state_q != S_IDLE);
  assign done_pulse = (state_q == S_FIN);
  assign error      = error_q;

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    count_d    = count_q;
    xfer_d     = xfer_q;
    rst_cnt_d  = rst_cnt_q;
    wait_cnt_d = wait_cnt_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (target == TGT_BAD) begin
            error_d = 1'b1;
            state_d = S_FIN;
          end else begin
            tgt_d     = target;
            count_d   = word_count;
            xfer_d    = '0;
            rst_cnt_d = '0;
            error_d   = 1'b0;
            state_d   = S_RST;
          end
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_W'(G_RESET_CYCLES - 1)) begin
          wait_cnt_d = '0;
          state_d    = (count_q == '0) ? S_WAIT_DONE : S_LOAD;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end
      S_LOAD: begin
        if (xfer) begin
          xfer_d = xfer_inc;
        end
        if (xfer && (xfer_inc == count_q)) begin
          wait_cnt_d = '0;
          state_d    = S_WAIT_DONE;
        end else if (sel_done) begin
          // Stage finished before receiving all words.
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_WAIT_DONE: begin
        // Counter is zero in the entry cycle; timeout fires once
        // G_TIMEOUT further cycles have elapsed without done.
        if (sel_done) begin
          state_d = S_FIN;
        end else if (wait_cnt_q == TO_W'(G_TIMEOUT)) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      count_q    <= '0;
      xfer_q     <= '0;
      rst_cnt_q  <= '0;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      count_q    <= count_d;
      xfer_q     <= xfer_d;
      rst_cnt_q  <= rst_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      error_q    <= error_d;
    end
  end

endmodule

// File: tb/tb_tulip_dsp_prog_sequencer.sv
// Self-checking bench for tulip_dsp_prog_sequencer: randomized host words and
// handshakes, with a queue-based model of what each stage should receive.
module tb_tulip_dsp_prog_sequencer;

  localparam int unsigned DW = 24;
  localparam int unsigned TW = 16;
  localparam int unsigned RC = 4;
  localparam int unsigned TO = 4096;

  logic          clk, reset, start;
  logic [1:0]    target;
  logic [15:0]   word_count;
  logic          busy, done_pulse, error;
  logic [DW-1:0] host_din;
  logic          host_din_valid, host_din_ready;
  logic          lut_sw_resetn, usr_fir_sw_resetn, reverb_sw_resetn;
  logic [DW-1:0] lut_prog_din;
  logic          lut_prog_valid, lut_prog_ready, lut_prog_done;
  logic [TW-1:0] fir_prog_din;
  logic          fir_prog_valid, fir_prog_ready, fir_prog_done;
  logic [TW-1:0] rev_prog_din;
  logic          rev_prog_valid, rev_prog_ready, rev_prog_done;

  tulip_dsp_prog_sequencer #(
    .G_DWIDTH(DW), .G_TAP_DWIDTH(TW), .G_RESET_CYCLES(RC), .G_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target(target), .word_count(word_count),
    .busy(busy), .done_pulse(done_pulse), .error(error),
    .host_din(host_din), .host_din_valid(host_din_valid), .host_din_ready(host_din_ready),
    .lut_sw_resetn(lut_sw_resetn), .usr_fir_sw_resetn(usr_fir_sw_resetn),
    .reverb_sw_resetn(reverb_sw_resetn),
    .lut_prog_din(lut_prog_din), .lut_prog_valid(lut_prog_valid),
    .lut_prog_ready(lut_prog_ready), .lut_prog_done(lut_prog_done),
    .fir_prog_din(fir_prog_din), .fir_prog_valid(fir_prog_valid),
    .fir_prog_ready(fir_prog_ready), .fir_prog_done(fir_prog_done),
    .rev_prog_din(rev_prog_din), .rev_prog_valid(rev_prog_valid),
    .rev_prog_ready(rev_prog_ready), .rev_prog_done(rev_prog_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard state
  int n_checks, n_pass, n_fail;
  int cyc;
  logic [DW-1:0] host_q[$];
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] rx_lut[$];
  logic [DW-1:0] rx_fir[$];
  logic [DW-1:0] rx_rev[$];

  // Stimulus knobs
  int cur_tgt, valid_pct, exp_wc;
  int rdy_mode[3];
  int done_en, done_after, done_delay, done_gate_rdy;
  int dcnt;
  logic tog, pop_now, dn;

  // Observed statistics
  int acc_cyc, first_low, first_xfer, last_xfer, pulse_cyc, done_first;
  int pulses, ready_late, bad_valid;
  int low_cnt[3];

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int rx_size(input int s);
    case (s)
      0: return rx_lut.size();
      1: return rx_fir.size();
      2: return rx_rev.size();
      default: return 0;
    endcase
  endfunction

  function automatic logic [DW-1:0] rx_get(input int s, input int i);
    case (s)
      0: return rx_lut[i];
      1: return rx_fir[i];
      default: return rx_rev[i];
    endcase
  endfunction

  // Count positions where the stage did not receive the expected host word.
  function automatic int mism(input int s, input int n, input bit tap);
    int m;
    logic [DW-1:0] e;
    m = 0;
    for (int i = 0; i < n; i++) begin
      if (i >= rx_size(s) || i >= src_q.size()) begin
        m++;
      end else begin
        e = src_q[i];
        if (tap) e = DW'(e[TW-1:0]);
        if (rx_get(s, i) !== e) m++;
      end
    end
    return m;
  endfunction

  // Monitor on the falling edge, driver just after the rising edge.
  initial begin
    logic [2:0] vv, rr;
    forever begin
      @(negedge clk);
      vv = {rev_prog_valid, fir_prog_valid, lut_prog_valid};
      rr = {rev_prog_ready, fir_prog_ready, lut_prog_ready};
      pop_now = host_din_valid && host_din_ready;
      if (start && !busy && !reset && acc_cyc < 0) acc_cyc = cyc;
      if (last_xfer >= 0 && cyc > last_xfer && cur_tgt < 3 &&
          rx_size(cur_tgt) >= exp_wc && host_din_ready) ready_late++;
      for (int s = 0; s < 3; s++) begin
        if (vv[s] && (!busy || s != cur_tgt)) bad_valid++;
        if (vv[s] && rr[s]) begin
          if (s == 0) rx_lut.push_back(lut_prog_din);
          if (s == 1) rx_fir.push_back(DW'(fir_prog_din));
          if (s == 2) rx_rev.push_back(DW'(rev_prog_din));
          if (first_xfer < 0) first_xfer = cyc;
          last_xfer = cyc;
        end
      end
      if (!lut_sw_resetn) low_cnt[0]++;
      if (!usr_fir_sw_resetn) low_cnt[1]++;
      if (!reverb_sw_resetn) low_cnt[2]++;
      if ((!lut_sw_resetn || !usr_fir_sw_resetn || !reverb_sw_resetn) && first_low < 0)
        first_low = cyc;
      if (done_pulse) begin
        pulses++;
        pulse_cyc = cyc;
      end
      if (busy && done_first < 0 &&
          ((cur_tgt == 0 && lut_prog_done) || (cur_tgt == 1 && fir_prog_done) ||
           (cur_tgt == 2 && rev_prog_done))) done_first = cyc;

      @(posedge clk);
      cyc++;
      #1;
      if (pop_now && host_q.size() > 0) void'(host_q.pop_front());
      tog = ~tog;
      if (done_en != 0 && cur_tgt < 3 && rx_size(cur_tgt) >= done_after) dcnt++;
      else dcnt = 0;
      dn = (dcnt > done_delay);
      lut_prog_done = dn && (cur_tgt == 0);
      fir_prog_done = dn && (cur_tgt == 1);
      rev_prog_done = dn && (cur_tgt == 2);
      lut_prog_ready = ((rdy_mode[0] == 0) ? 1'b1 : (rdy_mode[0] == 1) ? tog : 1'($urandom))
                       && !(done_gate_rdy != 0 && lut_prog_done);
      fir_prog_ready = ((rdy_mode[1] == 0) ? 1'b1 : (rdy_mode[1] == 1) ? tog : 1'($urandom))
                       && !(done_gate_rdy != 0 && fir_prog_done);
      rev_prog_ready = ((rdy_mode[2] == 0) ? 1'b1 : (rdy_mode[2] == 1) ? tog : 1'($urandom))
                       && !(done_gate_rdy != 0 && rev_prog_done);
      host_din_valid = (host_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
      host_din = (host_q.size() > 0) ? host_q[0] : DW'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_stats();
    rx_lut.delete(); rx_fir.delete(); rx_rev.delete();
    acc_cyc = -1; first_low = -1; first_xfer = -1; last_xfer = -1;
    pulse_cyc = -1; done_first = -1;
    pulses = 0; ready_late = 0; bad_valid = 0; dcnt = 0;
    for (int s = 0; s < 3; s++) low_cnt[s] = 0;
  endtask

  task automatic load_host(input int n);
    logic [DW-1:0] w;
    host_q.delete();
    src_q.delete();
    for (int i = 0; i < n; i++) begin
      w = DW'($urandom);
      host_q.push_back(w);
      src_q.push_back(w);
    end
  endtask

  task automatic set_rdy(input int m0, input int m1, input int m2);
    rdy_mode[0] = m0; rdy_mode[1] = m1; rdy_mode[2] = m2;
  endtask

  task automatic issue(input int t, input int wc);
    cur_tgt    = t;
    exp_wc     = wc;
    start      = 1'b1;
    target     = 2'(t);
    word_count = 16'(wc);
    tick();
    start      = 1'b0;
    target     = 2'($urandom);
    word_count = 16'($urandom);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (!(pulses > 0 && !busy) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, int'(n < budget), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; target = '0; word_count = '0;
    host_din = '0; host_din_valid = 1'b0;
    lut_prog_ready = 1'b0; fir_prog_ready = 1'b0; rev_prog_ready = 1'b0;
    lut_prog_done = 1'b0; fir_prog_done = 1'b0; rev_prog_done = 1'b0;
    cur_tgt = 3; valid_pct = 100; exp_wc = 0; tog = 1'b0; pop_now = 1'b0; dn = 1'b0;
    done_en = 0; done_after = 0; done_delay = 0; done_gate_rdy = 0;
    set_rdy(0, 0, 0);
    clear_stats();

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done_pulse", done_pulse, 0);
    chk("rst_error", error, 0);
    chk("rst_sw_resetn", {lut_sw_resetn, usr_fir_sw_resetn, reverb_sw_resetn}, 7);
    chk("rst_valids", {lut_prog_valid, fir_prog_valid, rev_prog_valid}, 0);
    chk("rst_host_ready", host_din_ready, 0);
    reset = 1'b0;
    tick();

    // LUT load, no backpressure
    clear_stats(); load_host(1030); valid_pct = 100; set_rdy(0, 0, 0);
    done_en = 1; done_after = 1025; done_delay = 0; done_gate_rdy = 0;
    issue(0, 1025);
    wait_idle("lut_complete", 3000);
    chk("lut_words", rx_size(0), 1025);
    chk("lut_order", mism(0, 1025, 1'b0), 0);
    chk("lut_rst_low", low_cnt[0], int'(RC));
    chk("lut_other_rst", low_cnt[1] + low_cnt[2], 0);
    chk("lut_rst_start", first_low - acc_cyc, 1);
    chk("lut_first_word", first_xfer - acc_cyc, int'(RC) + 1);
    chk("lut_pulses", pulses, 1);
    chk("lut_error", error, 0);
    chk("lut_pulse_latency", pulse_cyc - done_first, 1);
    chk("lut_host_left", host_q.size(), 5);
    chk("lut_bad_valid", bad_valid, 0);

    // FIR load with backpressure and host gaps
    clear_stats(); load_host(132); valid_pct = 70; set_rdy(2, 1, 2);
    done_en = 1; done_after = 129; done_delay = 4;
    issue(1, 129);
    wait_idle("fir_complete", 2000);
    chk("fir_words", rx_size(1), 129);
    chk("fir_taps", mism(1, 129, 1'b1), 0);
    chk("fir_ready_after_last", ready_late, 0);
    chk("fir_rst_low", low_cnt[1], int'(RC));
    chk("fir_pulses", pulses, 1);
    chk("fir_error", error, 0);
    chk("fir_bad_valid", bad_valid + rx_size(0) + rx_size(2), 0);
    chk("fir_host_left", host_q.size(), 3);

    // Invalid target
    clear_stats(); load_host(6); valid_pct = 100; set_rdy(0, 0, 0);
    done_en = 0; done_delay = 0;
    issue(3, 7);
    wait_idle("bad_complete", 50);
    chk("bad_error", error, 1);
    chk("bad_pulse_latency", pulse_cyc - acc_cyc, 1);
    chk("bad_no_rst", low_cnt[0] + low_cnt[1] + low_cnt[2], 0);
    chk("bad_no_words", rx_size(0) + rx_size(1) + rx_size(2) + bad_valid, 0);
    chk("bad_host_left", host_q.size(), 6);
    chk("bad_pulses", pulses, 1);

    // Reverb load with a start issued while busy
    clear_stats(); load_host(40); valid_pct = 90; set_rdy(0, 0, 2);
    done_en = 1; done_after = 32; done_delay = 0;
    issue(2, 32);
    chk("rev_error_cleared", error, 0);
    repeat (6) tick();
    chk("rev_busy_mid", busy, 1);
    start = 1'b1; target = 2'd0; word_count = 16'd3;
    tick();
    start = 1'b0;
    wait_idle("rev_complete", 500);
    chk("rev_words", rx_size(2), 32);
    chk("rev_order", mism(2, 32, 1'b1), 0);
    chk("rev_rst_low", low_cnt[2], int'(RC));
    chk("rev_lut_untouched", low_cnt[0] + rx_size(0), 0);
    chk("rev_error", error, 0);
    chk("rev_host_left", host_q.size(), 8);
    repeat (4) tick();
    chk("rev_start_not_queued", busy, 0);
    chk("rev_pulses", pulses, 1);

    // Timeout in WAIT_DONE
    clear_stats(); load_host(4); valid_pct = 100; set_rdy(0, 0, 0);
    done_en = 0;
    issue(2, 4);
    wait_idle("to_complete", 5000);
    chk("to_words", rx_size(2), 4);
    chk("to_error", error, 1);
    chk("to_pulse_latency", pulse_cyc - last_xfer, int'(TO) + 2);
    chk("to_pulses", pulses, 1);

    // Early done during LOAD
    clear_stats(); load_host(10); valid_pct = 100; set_rdy(0, 0, 0);
    done_en = 1; done_after = 5; done_delay = 0; done_gate_rdy = 1;
    issue(1, 10);
    chk("early_error_cleared", error, 0);
    wait_idle("early_complete", 200);
    chk("early_words", rx_size(1), 5);
    chk("early_taps", mism(1, 5, 1'b1), 0);
    chk("early_error", error, 1);
    chk("early_pulses", pulses, 1);
    chk("early_host_left", host_q.size(), 5);
    done_gate_rdy = 0;

    // Reset during LOAD, then reissue
    clear_stats(); load_host(8); valid_pct = 100; set_rdy(0, 0, 0);
    done_en = 1; done_after = 8; done_delay = 0;
    issue(1, 8);
    n = 0;
    while (rx_size(1) < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_reached", int'(n < 100), 1);
    reset = 1'b1;
    tick();
    chk("mid_busy", busy, 0);
    chk("mid_sw_resetn", {lut_sw_resetn, usr_fir_sw_resetn, reverb_sw_resetn}, 7);
    chk("mid_valids", {lut_prog_valid, fir_prog_valid, rev_prog_valid}, 0);
    chk("mid_host_ready", host_din_ready, 0);
    chk("mid_error", error, 0);
    reset = 1'b0;
    tick();
    clear_stats(); load_host(8);
    issue(1, 8);
    wait_idle("reissue_complete", 200);
    chk("reissue_words", rx_size(1), 8);
    chk("reissue_taps", mism(1, 8, 1'b1), 0);
    chk("reissue_rst_low", low_cnt[1], int'(RC));
    chk("reissue_error", error, 0);
    chk("reissue_pulses", pulses, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
